// File: rtl/piano_pkg.sv
// ============================================================================
// Module      : piano_pkg
// Description : Shared note table, half-period helper and sequencer types.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package piano_pkg;

    localparam int unsigned c_note_c4 = 262;
    localparam int unsigned c_note_d  = 294;
    localparam int unsigned c_note_e  = 330;
    localparam int unsigned c_note_f  = 349;
    localparam int unsigned c_note_g  = 392;
    localparam int unsigned c_note_a  = 440;
    localparam int unsigned c_note_b  = 494;
    localparam int unsigned c_note_c5 = 523;

    localparam int unsigned c_rest_w  = 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    // Channels beyond the first octave repeat the scale one octave higher.
    function automatic int unsigned note_freq(input int unsigned idx);
        int unsigned base;
        case (idx % 8)
            0:       base = c_note_c4;
            1:       base = c_note_d;
            2:       base = c_note_e;
            3:       base = c_note_f;
            4:       base = c_note_g;
            5:       base = c_note_a;
            6:       base = c_note_b;
            default: base = c_note_c5;
        endcase
        return base << (idx / 8);
    endfunction

    function automatic int unsigned half_period(input int unsigned clk_hz,
                                                input int unsigned freq);
        int unsigned h;
        h = clk_hz / (2 * freq);
        return (h == 0) ? 1 : h;
    endfunction

    function automatic int unsigned entry_width(input int unsigned num_keys,
                                                input int unsigned dur_w);
        return c_rest_w + $clog2(num_keys) + dur_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tone_divider.sv
// ============================================================================
// Module      : tone_divider
// Description : Free-running square wave with a period of exactly 2*HALF cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tone_divider #(
    parameter int unsigned HALF = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic tone
);

    localparam int unsigned c_cnt_w = (HALF > 1) ? $clog2(HALF) : 1;

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_tone;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tone <= 1'b0;
        end else if (r_cnt == c_cnt_w'(HALF - 1)) begin
            r_cnt  <= '0;
            r_tone <= ~r_tone;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign tone = r_tone;

endmodule

`default_nettype wire

// File: rtl/tone_sequencer.sv
// ============================================================================
// Module      : tone_sequencer
// Description : NUM_KEYS live tone channels plus a beat-timed step sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tone_sequencer
    import piano_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 25000000,
    parameter int unsigned BEAT_HZ   = 50,
    parameter int unsigned NUM_KEYS  = 8,
    parameter int unsigned SEQ_DEPTH = 16,
    parameter int unsigned DUR_W     = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                mode,
    input  logic [NUM_KEYS-1:0]                 key_en,
    input  logic                                wr_en,
    input  logic [$clog2(SEQ_DEPTH)-1:0]        wr_addr,
    input  logic [$clog2(NUM_KEYS)+DUR_W:0]     wr_data,
    input  logic [$clog2(SEQ_DEPTH):0]          seq_len,
    input  logic                                loop,
    input  logic                                start,
    input  logic                                stop,
    output logic [NUM_KEYS-1:0]                 key_out,
    output logic                                seq_out,
    output logic                                busy,
    output logic                                done,
    output logic [$clog2(SEQ_DEPTH)-1:0]        step
);

    localparam int unsigned c_addr_w   = $clog2(SEQ_DEPTH);
    localparam int unsigned c_note_w   = $clog2(NUM_KEYS);
    localparam int unsigned c_entry_w  = entry_width(NUM_KEYS, DUR_W);
    localparam int unsigned c_tone_ext = 2 ** c_note_w;
    localparam int unsigned c_beat_cyc = CLK_HZ / BEAT_HZ;
    localparam int unsigned c_pre_w    = (c_beat_cyc > 1) ? $clog2(c_beat_cyc) : 1;

    logic [NUM_KEYS-1:0]   w_tone;
    logic [c_tone_ext-1:0] w_tone_ext;
    logic [c_entry_w-1:0]  r_table [SEQ_DEPTH];
    logic [c_pre_w-1:0]    r_pre;
    logic [DUR_W-1:0]      r_beat;
    logic [c_addr_w-1:0]   r_step;
    logic [NUM_KEYS-1:0]   r_key_out;
    logic                  r_seq_out;
    logic                  r_done;
    state_t                r_state;

    logic [c_entry_w-1:0]  w_cur;
    logic [DUR_W-1:0]      w_dur;
    logic [DUR_W-1:0]      w_last_beat;
    logic [c_addr_w-1:0]   w_step_nxt;
    logic                  w_is_last;
    logic                  w_tick;
    logic                  w_snd_cur;
    logic                  w_snd_nxt;
    logic                  w_snd_first;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
        tone_divider #(
            .HALF (half_period(CLK_HZ, note_freq(g)))
        ) u_div (
            .clk   (clk),
            .rst_n (rst_n),
            .tone  (w_tone[g])
        );
    end

    // Zero-extending to a power of two makes out-of-range notes read as silence.
    assign w_tone_ext = c_tone_ext'(w_tone);

    function automatic logic entry_sound(input logic [c_entry_w-1:0]  e,
                                         input logic [c_tone_ext-1:0] tones);
        logic [c_note_w-1:0] n;
        n = e[DUR_W +: c_note_w];
        return ~e[c_entry_w-1] & tones[n];
    endfunction

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_table[wr_addr] <= wr_data;
        end
    end

    assign w_cur       = r_table[r_step];
    assign w_dur       = w_cur[DUR_W-1:0];
    assign w_last_beat = (w_dur == '0) ? '0 : w_dur - 1'b1;
    assign w_step_nxt  = r_step + 1'b1;
    assign w_is_last   = ((c_addr_w + 1)'(r_step) + (c_addr_w + 1)'(1)) >= seq_len;
    assign w_tick      = (r_pre == c_pre_w'(c_beat_cyc - 1));
    assign w_snd_cur   = entry_sound(w_cur, w_tone_ext);
    assign w_snd_nxt   = entry_sound(r_table[w_step_nxt], w_tone_ext);
    assign w_snd_first = entry_sound(r_table[0], w_tone_ext);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else if (start || w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_out <= '0;
        end else begin
            r_key_out <= mode ? '0 : (w_tone & key_en);
        end
    end

    // seq_out is loaded with the sound of the step being entered so it stays aligned with step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_step    <= '0;
            r_beat    <= '0;
            r_seq_out <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!mode || stop) begin
                r_state   <= IDLE;
                r_step    <= '0;
                r_beat    <= '0;
                r_seq_out <= 1'b0;
            end else if (start && (seq_len != '0)) begin
                r_state   <= PLAY;
                r_step    <= '0;
                r_beat    <= '0;
                r_seq_out <= w_snd_first;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_seq_out <= 1'b0;
                    end
                    PLAY: begin
                        if (w_tick && (r_beat == w_last_beat)) begin
                            r_beat <= '0;
                            if (w_is_last && loop) begin
                                r_step    <= '0;
                                r_seq_out <= w_snd_first;
                            end else if (w_is_last) begin
                                r_state   <= IDLE;
                                r_step    <= '0;
                                r_seq_out <= 1'b0;
                                r_done    <= 1'b1;
                            end else begin
                                r_step    <= w_step_nxt;
                                r_seq_out <= w_snd_nxt;
                            end
                        end else begin
                            if (w_tick) begin
                                r_beat <= r_beat + 1'b1;
                            end
                            r_seq_out <= w_snd_cur;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign key_out = r_key_out;
    assign seq_out = r_seq_out;
    assign busy    = (r_state == PLAY);
    assign done    = r_done;
    assign step    = r_step;

endmodule

`default_nettype wire
